// File: rtl/apu_mixer_pkg.sv
// apu_mixer_pkg: shared constants and FSM state type for the APU stereo mixer.
// Register indices, CTRL bit positions, mixer state enum.
package apu_mixer_pkg;

  localparam logic [2:0] MIX_REG_MVOL   = 3'd0;
  localparam logic [2:0] MIX_REG_RMASK  = 3'd1;
  localparam logic [2:0] MIX_REG_LMASK  = 3'd2;
  localparam logic [2:0] MIX_REG_CTRL   = 3'd3;
  localparam logic [2:0] MIX_REG_STATUS = 3'd4;
  localparam logic [2:0] MIX_REG_PEAK_L = 3'd5;
  localparam logic [2:0] MIX_REG_PEAK_R = 3'd6;

  localparam int CTRL_MASTER_EN = 7;
  localparam int CTRL_OVERRUN   = 6;

  typedef enum logic [1:0] {
    MIX_IDLE,
    MIX_ACCUM,
    MIX_SCALE
  } mix_state_t;

endpackage

// File: rtl/apu_mix_regs.sv
// apu_mix_regs: CPU register bank (MVOL/RMASK/LMASK/CTRL/STATUS), rdata mux,
// sticky overrun, optional peak meters (MIXER_PEAK_EN). Outputs carry same-cycle writes.
module apu_mix_regs
  import apu_mixer_pkg::*;
#(
  parameter int NUM_CH = 4
`ifdef MIXER_PEAK_EN
  ,
  parameter int OUT_W = 9
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_en,
  input  logic              sel,
  input  logic              write,
  input  logic [2:0]        reg_addr,
  input  logic [7:0]        wdata,
  input  logic [NUM_CH-1:0] length_plays,
  input  logic              overrun_set,
`ifdef MIXER_PEAK_EN
  input  logic              sample_valid,
  input  logic [OUT_W-1:0]  sound_l,
  input  logic [OUT_W-1:0]  sound_r,
`endif
  output logic [7:0]        rdata,
  output logic [2:0]        vol_l,
  output logic [2:0]        vol_r,
  output logic [NUM_CH-1:0] rmask,
  output logic [NUM_CH-1:0] lmask,
  output logic              master_en
);

  logic              wr_en;
  logic [7:0]        mvol_q, mvol_d;
  logic [NUM_CH-1:0] rmask_q, rmask_d;
  logic [NUM_CH-1:0] lmask_q, lmask_d;
  logic              master_en_q, master_en_d;
  logic              overrun_q, overrun_d;

  assign wr_en = write & sel & cpu_en;

  always_comb begin
    mvol_d      = mvol_q;
    rmask_d     = rmask_q;
    lmask_d     = lmask_q;
    master_en_d = master_en_q;
    overrun_d   = overrun_q;
    if (wr_en) begin
      case (reg_addr)
        MIX_REG_MVOL:  mvol_d  = wdata;
        MIX_REG_RMASK: rmask_d = wdata[NUM_CH-1:0];
        MIX_REG_LMASK: lmask_d = wdata[NUM_CH-1:0];
        MIX_REG_CTRL: begin
          master_en_d = wdata[CTRL_MASTER_EN];
          overrun_d   = 1'b0;
        end
        default: ;
      endcase
    end
    // a new overrun beats a clearing write in the same cycle
    if (overrun_set) overrun_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mvol_q      <= '0;
      rmask_q     <= '0;
      lmask_q     <= '0;
      master_en_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      mvol_q      <= mvol_d;
      rmask_q     <= rmask_d;
      lmask_q     <= lmask_d;
      master_en_q <= master_en_d;
      overrun_q   <= overrun_d;
    end
  end

  // forwarded values: a write lands in the datapath the cycle it is issued
  assign vol_l     = mvol_d[6:4];
  assign vol_r     = mvol_d[2:0];
  assign rmask     = rmask_d;
  assign lmask     = lmask_d;
  assign master_en = master_en_d;

`ifdef MIXER_PEAK_EN
  logic             rd_en;
  logic [OUT_W-1:0] peak_l_q, peak_l_d;
  logic [OUT_W-1:0] peak_r_q, peak_r_d;

  assign rd_en = sel & cpu_en & ~write;

  always_comb begin
    peak_l_d = peak_l_q;
    peak_r_d = peak_r_q;
    if (rd_en && reg_addr == MIX_REG_PEAK_L) peak_l_d = '0;
    if (rd_en && reg_addr == MIX_REG_PEAK_R) peak_r_d = '0;
    if (sample_valid && sound_l > peak_l_d) peak_l_d = sound_l;
    if (sample_valid && sound_r > peak_r_d) peak_r_d = sound_r;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      peak_l_q <= '0;
      peak_r_q <= '0;
    end else begin
      peak_l_q <= peak_l_d;
      peak_r_q <= peak_r_d;
    end
  end
`endif

  always_comb begin
    rdata = '0;
    if (sel) begin
      case (reg_addr)
        MIX_REG_MVOL:   rdata = mvol_q;
        MIX_REG_RMASK:  rdata = 8'(rmask_q);
        MIX_REG_LMASK:  rdata = 8'(lmask_q);
        MIX_REG_CTRL:   rdata = {master_en_q, overrun_q, 6'b0};
        MIX_REG_STATUS: rdata = 8'(length_plays & {NUM_CH{master_en_q}});
`ifdef MIXER_PEAK_EN
        MIX_REG_PEAK_L: rdata = peak_l_q[OUT_W-1 -: 8];
        MIX_REG_PEAK_R: rdata = peak_r_q[OUT_W-1 -: 8];
`endif
        default:        rdata = '0;
      endcase
    end
  end

endmodule

// File: rtl/apu_stereo_mixer_seq.sv
// apu_stereo_mixer_seq: sequential stereo mixer, one channel per clock, then scale+saturate.
// Ports: CPU reg bus (cpu_en/sel/reg_addr/wdata/write/rdata), waves/ch_off/length_plays,
// sample_en in; sound_r/sound_l/sample_valid/busy out. Peak meters with MIXER_PEAK_EN.
module apu_stereo_mixer_seq
  import apu_mixer_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int WAVE_W = 4,
  parameter int OUT_W  = 9
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cpu_en,
  input  logic                     sample_en,
  input  logic                     sel,
  input  logic [2:0]               reg_addr,
  input  logic [7:0]               wdata,
  input  logic                     write,
  output logic [7:0]               rdata,
  input  logic [NUM_CH*WAVE_W-1:0] waves,
  input  logic [NUM_CH-1:0]        length_plays,
  input  logic [NUM_CH-1:0]        ch_off,
  output logic [OUT_W-1:0]         sound_r,
  output logic [OUT_W-1:0]         sound_l,
  output logic                     sample_valid,
  output logic                     busy
);

  localparam int ACC_W  = WAVE_W + $clog2(NUM_CH + 1);
  localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PROD_W = ACC_W + 4;
  localparam int WIDE_W = ((PROD_W > OUT_W) ? PROD_W : OUT_W) + 1;

  mix_state_t        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [ACC_W-1:0]  acc_r_q, acc_r_d;
  logic [ACC_W-1:0]  acc_l_q, acc_l_d;
  logic [OUT_W-1:0]  sound_r_q, sound_r_d;
  logic [OUT_W-1:0]  sound_l_q, sound_l_d;
  logic              valid_q, valid_d;
  logic              overrun_set;
  logic [WAVE_W-1:0] wave_cur;
  logic [2:0]        vol_l, vol_r;
  logic [NUM_CH-1:0] rmask, lmask;
  logic              master_en;

  function automatic logic [OUT_W-1:0] scale_sat(
    input logic [ACC_W-1:0] acc,
    input logic [2:0]       vol
  );
    logic [WIDE_W-1:0] prod;
    prod = WIDE_W'(acc) * WIDE_W'({1'b0, vol} + 4'd1);
    if (prod > WIDE_W'({OUT_W{1'b1}})) return '1;
    return prod[OUT_W-1:0];
  endfunction

  assign wave_cur = waves[idx_q*WAVE_W +: WAVE_W];

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    acc_r_d     = acc_r_q;
    acc_l_d     = acc_l_q;
    sound_r_d   = sound_r_q;
    sound_l_d   = sound_l_q;
    valid_d     = 1'b0;
    overrun_set = 1'b0;
    unique case (state_q)
      MIX_IDLE: begin
        if (sample_en) begin
          acc_r_d = '0;
          acc_l_d = '0;
          idx_d   = '0;
          state_d = MIX_ACCUM;
        end
      end
      MIX_ACCUM: begin
        if (!ch_off[idx_q]) begin
          if (rmask[idx_q]) acc_r_d = acc_r_q + ACC_W'(wave_cur);
          if (lmask[idx_q]) acc_l_d = acc_l_q + ACC_W'(wave_cur);
        end
        if (sample_en) overrun_set = 1'b1;
        if (idx_q == IDX_W'(NUM_CH - 1)) state_d = MIX_SCALE;
        else idx_d = idx_q + IDX_W'(1);
      end
      MIX_SCALE: begin
        sound_r_d = master_en ? scale_sat(acc_r_q, vol_r) : '0;
        sound_l_d = master_en ? scale_sat(acc_l_q, vol_l) : '0;
        valid_d   = 1'b1;
        state_d   = MIX_IDLE;
        // a start request on the way back to idle is taken, not an overrun
        if (sample_en) begin
          acc_r_d = '0;
          acc_l_d = '0;
          idx_d   = '0;
          state_d = MIX_ACCUM;
        end
      end
      default: state_d = MIX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= MIX_IDLE;
      idx_q     <= '0;
      acc_r_q   <= '0;
      acc_l_q   <= '0;
      sound_r_q <= '0;
      sound_l_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      acc_r_q   <= acc_r_d;
      acc_l_q   <= acc_l_d;
      sound_r_q <= sound_r_d;
      sound_l_q <= sound_l_d;
      valid_q   <= valid_d;
    end
  end

  assign sound_r      = sound_r_q;
  assign sound_l      = sound_l_q;
  assign sample_valid = valid_q;
  assign busy         = (state_q != MIX_IDLE);

  apu_mix_regs #(
    .NUM_CH(NUM_CH)
`ifdef MIXER_PEAK_EN
    ,
    .OUT_W(OUT_W)
`endif
  ) u_regs (
    .clk         (clk),
    .reset       (reset),
    .cpu_en      (cpu_en),
    .sel         (sel),
    .write       (write),
    .reg_addr    (reg_addr),
    .wdata       (wdata),
    .length_plays(length_plays),
    .overrun_set (overrun_set),
`ifdef MIXER_PEAK_EN
    .sample_valid(valid_q),
    .sound_l     (sound_l_q),
    .sound_r     (sound_r_q),
`endif
    .rdata       (rdata),
    .vol_l       (vol_l),
    .vol_r       (vol_r),
    .rmask       (rmask),
    .lmask       (lmask),
    .master_en   (master_en)
  );

endmodule

// File: tb/tb_apu_stereo_mixer_seq.sv
// tb_apu_stereo_mixer_seq: directed stimulus, cycle-level behavioural model,
// per-cycle compare plus literal checks; second instance with OUT_W=8.
module tb_apu_stereo_mixer_seq;

  localparam int N   = 4;
  localparam int WW  = 4;
  localparam int OW  = 9;
  localparam int OW8 = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cpu_en = 1'b0;
  logic          sample_en = 1'b0;
  logic          sel = 1'b0;
  logic          write = 1'b0;
  logic [2:0]    reg_addr = '0;
  logic [7:0]    wdata = '0;
  logic [N*WW-1:0] waves = '0;
  logic [N-1:0]  length_plays = '0;
  logic [N-1:0]  ch_off = '0;

  logic [7:0]    rdata, rdata8;
  logic [OW-1:0] sound_r, sound_l;
  logic [OW8-1:0] sound_r8, sound_l8;
  logic          sample_valid, valid8, busy, busy8;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  apu_stereo_mixer_seq #(.NUM_CH(N), .WAVE_W(WW), .OUT_W(OW)) dut (
    .clk(clk), .reset(reset), .cpu_en(cpu_en), .sample_en(sample_en),
    .sel(sel), .reg_addr(reg_addr), .wdata(wdata), .write(write),
    .rdata(rdata), .waves(waves), .length_plays(length_plays),
    .ch_off(ch_off), .sound_r(sound_r), .sound_l(sound_l),
    .sample_valid(sample_valid), .busy(busy)
  );

  apu_stereo_mixer_seq #(.NUM_CH(N), .WAVE_W(WW), .OUT_W(OW8)) dut8 (
    .clk(clk), .reset(reset), .cpu_en(cpu_en), .sample_en(sample_en),
    .sel(sel), .reg_addr(reg_addr), .wdata(wdata), .write(write),
    .rdata(rdata8), .waves(waves), .length_plays(length_plays),
    .ch_off(ch_off), .sound_r(sound_r8), .sound_l(sound_l8),
    .sample_valid(valid8), .busy(busy8)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_phase, m_sum_r, m_sum_l;
  int e_r, e_l, e_r8, e_l8, e_valid;
  int m_mvol, m_rmask, m_lmask, m_master, m_ov, m_pk_l, m_pk_r;
  int t_wr, t_rm, t_lm, t_mv, t_me, t_ch, t_w, t_ovs, t_nv;

  function automatic int sat(input int sum, input int vol, input int ow);
    int p;
    int mx;
    p = sum * (vol + 1);
    mx = (1 << ow) - 1;
    return (p > mx) ? mx : p;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase = 0; m_sum_r = 0; m_sum_l = 0;
      e_r = 0; e_l = 0; e_r8 = 0; e_l8 = 0; e_valid = 0;
      m_mvol = 0; m_rmask = 0; m_lmask = 0; m_master = 0; m_ov = 0;
      m_pk_l = 0; m_pk_r = 0;
    end else begin
      t_wr = int'(write && sel && cpu_en);
      t_rm = (t_wr != 0 && reg_addr == 1) ? (int'(wdata) & ((1 << N) - 1)) : m_rmask;
      t_lm = (t_wr != 0 && reg_addr == 2) ? (int'(wdata) & ((1 << N) - 1)) : m_lmask;
      t_mv = (t_wr != 0 && reg_addr == 0) ? int'(wdata) : m_mvol;
      t_me = (t_wr != 0 && reg_addr == 3) ? int'(wdata[7]) : m_master;
      t_ovs = 0;
      t_nv = 0;
      // peaks track the sample currently on the outputs
      if (sel && cpu_en && !write && reg_addr == 5) m_pk_l = 0;
      if (sel && cpu_en && !write && reg_addr == 6) m_pk_r = 0;
      if (e_valid != 0 && e_l > m_pk_l) m_pk_l = e_l;
      if (e_valid != 0 && e_r > m_pk_r) m_pk_r = e_r;
      if (m_phase == 0) begin
        if (sample_en) begin
          m_sum_r = 0; m_sum_l = 0; m_phase = 1;
        end
      end else if (m_phase <= N) begin
        t_ch = m_phase - 1;
        if (!ch_off[t_ch]) begin
          t_w = int'(waves >> (t_ch * WW)) & ((1 << WW) - 1);
          if (((t_rm >> t_ch) & 1) != 0) m_sum_r += t_w;
          if (((t_lm >> t_ch) & 1) != 0) m_sum_l += t_w;
        end
        if (sample_en) t_ovs = 1;
        m_phase++;
      end else begin
        e_r  = (t_me != 0) ? sat(m_sum_r, t_mv & 7, OW) : 0;
        e_l  = (t_me != 0) ? sat(m_sum_l, (t_mv >> 4) & 7, OW) : 0;
        e_r8 = (t_me != 0) ? sat(m_sum_r, t_mv & 7, OW8) : 0;
        e_l8 = (t_me != 0) ? sat(m_sum_l, (t_mv >> 4) & 7, OW8) : 0;
        t_nv = 1;
        if (sample_en) begin
          m_sum_r = 0; m_sum_l = 0; m_phase = 1;
        end else begin
          m_phase = 0;
        end
      end
      e_valid = t_nv;
      if (t_wr != 0) begin
        case (reg_addr)
          3'd0: m_mvol = int'(wdata);
          3'd1: m_rmask = int'(wdata) & ((1 << N) - 1);
          3'd2: m_lmask = int'(wdata) & ((1 << N) - 1);
          3'd3: begin m_master = int'(wdata[7]); m_ov = 0; end
          default: ;
        endcase
      end
      if (t_ovs != 0) m_ov = 1;
    end
  end

  function automatic int exp_rd(input logic [2:0] a, input int ow);
    if (!sel) return 0;
    case (a)
      3'd0: return m_mvol;
      3'd1: return m_rmask;
      3'd2: return m_lmask;
      3'd3: return (m_master << 7) | (m_ov << 6);
      3'd4: return (m_master != 0) ? int'(length_plays) : 0;
`ifdef MIXER_PEAK_EN
      3'd5: return (m_pk_l >> (ow - 8)) & 8'hFF;
      3'd6: return (m_pk_r >> (ow - 8)) & 8'hFF;
`endif
      default: return 0;
    endcase
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      check("sound_r", 32'(sound_r), 32'(e_r));
      check("sound_l", 32'(sound_l), 32'(e_l));
      check("sound_r8", 32'(sound_r8), 32'(e_r8));
      check("sound_l8", 32'(sound_l8), 32'(e_l8));
      check("sample_valid", 32'(sample_valid), 32'(e_valid));
      check("busy", 32'(busy), 32'(m_phase != 0));
      check("rdata", 32'(rdata), 32'(exp_rd(reg_addr, OW)));
      if (reg_addr < 3'd5) check("rdata8", 32'(rdata8), 32'(exp_rd(reg_addr, OW8)));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    sel = 1'b1; cpu_en = 1'b1; write = 1'b1; reg_addr = a; wdata = d;
    tick();
    sel = 1'b0; cpu_en = 1'b0; write = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [7:0] v);
    sel = 1'b1; cpu_en = 1'b1; write = 1'b0; reg_addr = a;
    #1 v = rdata;
    tick();
    sel = 1'b0; cpu_en = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 1;
    while (!sample_valid && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic mix(output int n);
    sample_en = 1'b1;
    tick();
    sample_en = 1'b0;
    wait_valid(n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic [7:0] v;
    tick();
    tick();
    check("rst_sound_r", 32'(sound_r), 0);
    check("rst_sound_l", 32'(sound_l), 0);
    check("rst_valid", 32'(sample_valid), 0);
    check("rst_busy", 32'(busy), 0);
    reset = 1'b0;
    tick();
    rd(3'd3, v);
    check("rst_ctrl", 32'(v), 0);

    // full scale
    waves = 16'hFFFF;
    wr(3'd1, 8'hFF);
    wr(3'd2, 8'h0F);
    wr(3'd0, 8'h77);
    wr(3'd3, 8'h80);
    rd(3'd1, v);
    check("rmask_upper_bits", 32'(v), 32'h0F);
    rd(3'd0, v);
    check("mvol_rb", 32'(v), 32'h77);
    mix(n);
    check("full_latency", 32'(n), 6);
    check("full_r", 32'(sound_r), 32'h1E0);
    check("full_l", 32'(sound_l), 32'h1E0);
    check("sat_r8", 32'(sound_r8), 32'hFF);
    check("sat_l8", 32'(sound_l8), 32'hFF);
    rd(3'd7, v);
    check("reg7", 32'(v), 0);
`ifndef MIXER_PEAK_EN
    rd(3'd5, v);
    check("reg5_nopeak", 32'(v), 0);
`endif

    // master disabled
    wr(3'd3, 8'h00);
    mix(n);
    check("off_r", 32'(sound_r), 0);
    check("off_l8", 32'(sound_l8), 0);
    wr(3'd3, 8'h80);

    // panning and volume
    waves = 16'h0053;
    wr(3'd1, 8'h01);
    wr(3'd2, 8'h02);
    wr(3'd0, 8'h10);
    mix(n);
    check("pan_r", 32'(sound_r), 3);
    check("pan_l", 32'(sound_l), 10);
    length_plays = 4'b1011;
    rd(3'd4, v);
    check("status", 32'(v), 32'h0B);

    // overrun
    sample_en = 1'b1;
    tick();
    sample_en = 1'b0;
    tick();
    sample_en = 1'b1;
    tick();
    sample_en = 1'b0;
    n = 0;
    repeat (10) begin
      if (sample_valid) n++;
      tick();
    end
    check("ovr_valids", 32'(n), 1);
    rd(3'd3, v);
    check("ovr_ctrl", 32'(v), 32'hC0);
    wr(3'd3, 8'h80);
    rd(3'd3, v);
    check("ovr_clear", 32'(v), 32'h80);

    // mute and mid-mix mask write
    waves = 16'h8421;
    wr(3'd1, 8'h0F);
    wr(3'd2, 8'h0F);
    wr(3'd0, 8'h00);
    ch_off = 4'b0001;
    sample_en = 1'b1;
    tick();
    sample_en = 1'b0;
    tick();
    tick();
    wr(3'd1, 8'h00);
    wait_valid(n);
    check("midmix_r", 32'(sound_r), 2);
    check("midmix_l", 32'(sound_l), 14);
    ch_off = '0;

    // reset mid-mix
    wr(3'd1, 8'h0F);
    sample_en = 1'b1;
    tick();
    sample_en = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 0);
    check("abort_r", 32'(sound_r), 0);
    check("abort_valid", 32'(sample_valid), 0);
    tick();
    reset = 1'b0;
    n = 0;
    repeat (10) begin
      tick();
      if (sample_valid) n++;
    end
    check("abort_no_valid", 32'(n), 0);

`ifdef MIXER_PEAK_EN
    waves = 16'h0088;
    wr(3'd3, 8'h80);
    wr(3'd2, 8'h03);
    wr(3'd0, 8'h30);
    mix(n);
    check("peak_s1", 32'(sound_l), 32'h40);
    wr(3'd0, 8'h10);
    mix(n);
    check("peak_s2", 32'(sound_l), 32'h20);
    tick();
    rd(3'd5, v);
    check("peak_l", 32'(v), 32'h20);
    rd(3'd5, v);
    check("peak_l_clr", 32'(v), 0);
`endif

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
